// File: rtl/timer_intc_pkg.sv
//------------------------------------------------------------------------------
// timer_intc_pkg : shared constants for the timer interrupt controller
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package timer_intc_pkg;

    localparam int SRC_CMIA0 = 0;
    localparam int SRC_CMIB0 = 1;
    localparam int SRC_OVI0  = 2;
    localparam int SRC_CMIA1 = 3;
    localparam int SRC_CMIB1 = 4;
    localparam int SRC_OVI1  = 5;
    localparam int SRC_CMIA2 = 6;
    localparam int SRC_CMIB2 = 7;
    localparam int SRC_OVI2  = 8;
    localparam int SRC_CMIA3 = 9;
    localparam int SRC_CMIB3 = 10;
    localparam int SRC_OVI3  = 11;

    localparam logic [1:0] ADDR_IER    = 2'd0;
    localparam logic [1:0] ADDR_IPR_LO = 2'd1;
    localparam logic [1:0] ADDR_IPR_HI = 2'd2;
    localparam logic [1:0] ADDR_PEND   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/intc_prio_arbiter.sv
//------------------------------------------------------------------------------
// intc_prio_arbiter : combinational highest-priority pick, lowest index on ties
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module intc_prio_arbiter
    import timer_intc_pkg::*;
#(
    parameter int NUM_SRC    = 12,
    parameter int VEC_WIDTH  = 4,
    parameter int PRIO_WIDTH = 2
) (
    input  logic [NUM_SRC-1:0]            eligible,
    input  logic [NUM_SRC*PRIO_WIDTH-1:0] ipr,
    output logic                          any,
    output logic [VEC_WIDTH-1:0]          idx,
    output logic [PRIO_WIDTH-1:0]         prio
);

    // Scan downward and accept >= so the lowest index wins equal priorities.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        prio = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i] && (!any || ipr[i*PRIO_WIDTH +: PRIO_WIDTH] >= prio)) begin
                any  = 1'b1;
                idx  = VEC_WIDTH'(i);
                prio = ipr[i*PRIO_WIDTH +: PRIO_WIDTH];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_intc.sv
//------------------------------------------------------------------------------
// timer_intc : edge-latched, masked, prioritised vectored interrupt controller
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module timer_intc
    import timer_intc_pkg::*;
#(
    parameter int NUM_SRC    = 12,
    parameter int VEC_WIDTH  = 4,
    parameter int PRIO_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    irq_src,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_addr,
    input  logic [15:0]           cfg_wdata,
    output logic [15:0]           cfg_rdata,
    output logic                  irq_req,
    output logic [VEC_WIDTH-1:0]  irq_vec,
    output logic [PRIO_WIDTH-1:0] irq_prio,
    input  logic                  irq_ack,
    input  logic                  irq_eoi,
    output logic [NUM_SRC-1:0]    flag_clr
);

    // IPR spans a full low word plus a partial high word (17..32 bits total).
    localparam int IPR_BITS    = NUM_SRC * PRIO_WIDTH;
    localparam int IPR_HI_BITS = IPR_BITS - 16;

    logic [NUM_SRC-1:0]    r_src_d;
    logic [NUM_SRC-1:0]    r_pend;
    logic [NUM_SRC-1:0]    r_ier;
    logic [IPR_BITS-1:0]   r_ipr;
    state_t                r_state;

    logic [NUM_SRC-1:0]    w_rise;
    logic [NUM_SRC-1:0]    w_elig;
    logic [NUM_SRC-1:0]    w_clr;
    logic [NUM_SRC-1:0]    w_vec_onehot;
    logic                  w_ack;
    logic                  w_any;
    logic [VEC_WIDTH-1:0]  w_idx;
    logic [PRIO_WIDTH-1:0] w_prio;
    logic [15:0]           w_rdata;

    assign w_rise       = irq_src & ~r_src_d;
    assign w_elig       = r_pend & r_ier;
    assign w_ack        = (r_state == ST_REQ) && irq_ack;
    assign w_vec_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << irq_vec;
    assign w_clr        = ((cfg_we && cfg_addr == ADDR_PEND) ? cfg_wdata[NUM_SRC-1:0] : '0)
                        | (w_ack ? w_vec_onehot : '0);

    intc_prio_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .VEC_WIDTH  (VEC_WIDTH),
        .PRIO_WIDTH (PRIO_WIDTH)
    ) u_arb (
        .eligible (w_elig),
        .ipr      (r_ipr),
        .any      (w_any),
        .idx      (w_idx),
        .prio     (w_prio)
    );

    always_comb begin
        w_rdata = '0;
        case (cfg_addr)
            ADDR_IER:    w_rdata = 16'(r_ier);
            ADDR_IPR_LO: w_rdata = r_ipr[15:0];
            ADDR_IPR_HI: w_rdata = 16'(r_ipr[IPR_BITS-1:16]);
            default:     w_rdata = 16'(r_pend);
        endcase
    end

    // Edge detect, pending latch (set beats clear) and config registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_d   <= '0;
            r_pend    <= '0;
            r_ier     <= '0;
            r_ipr     <= '0;
            cfg_rdata <= '0;
        end else begin
            r_src_d   <= irq_src;
            r_pend    <= (r_pend & ~w_clr) | w_rise;
            cfg_rdata <= w_rdata;
            if (cfg_we && cfg_addr == ADDR_IER) begin
                r_ier <= cfg_wdata[NUM_SRC-1:0];
            end
            if (cfg_we && cfg_addr == ADDR_IPR_LO) begin
                r_ipr[15:0] <= cfg_wdata;
            end
            if (cfg_we && cfg_addr == ADDR_IPR_HI) begin
                r_ipr[IPR_BITS-1:16] <= cfg_wdata[IPR_HI_BITS-1:0];
            end
        end
    end

    // Request handshake; vector and priority stay frozen from load until ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            irq_req  <= 1'b0;
            irq_vec  <= '0;
            irq_prio <= '0;
            flag_clr <= '0;
        end else begin
            flag_clr <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        irq_req  <= 1'b1;
                        irq_vec  <= w_idx;
                        irq_prio <= w_prio;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        irq_req  <= 1'b0;
                        flag_clr <= w_vec_onehot;
                        r_state  <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (irq_eoi) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_timer_intc.sv
//------------------------------------------------------------------------------
// tb_timer_intc : directed scenarios plus random traffic against a reference model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_timer_intc;
    import timer_intc_pkg::*;

    localparam int N = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [N-1:0] irq_src = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_wdata = '0;
    logic [15:0] cfg_rdata;
    logic        irq_req;
    logic [3:0]  irq_vec;
    logic [1:0]  irq_prio;
    logic        irq_ack = 1'b0;
    logic        irq_eoi = 1'b0;
    logic [N-1:0] flag_clr;

    timer_intc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_prio  (irq_prio),
        .irq_ack   (irq_ack),
        .irq_eoi   (irq_eoi),
        .flag_clr  (flag_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: 0 = waiting, 1 = requesting, 2 = in service.
    logic [N-1:0] m_src_d, m_pend, m_ier, m_flag;
    int           m_ipr [N];
    int           m_mode, m_vec, m_prio;
    logic         m_req;
    logic [15:0]  m_rdata;

    task automatic model_reset();
        m_src_d = '0; m_pend = '0; m_ier = '0; m_flag = '0;
        for (int i = 0; i < N; i++) m_ipr[i] = 0;
        m_mode = 0; m_vec = 0; m_prio = 0; m_req = 1'b0; m_rdata = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] rise, elig, clr;
        logic [23:0]  iprw;
        logic [15:0]  rd;
        int best, bp;
        rise = irq_src & ~m_src_d;
        elig = m_pend & m_ier;
        best = -1; bp = -1;
        for (int i = 0; i < N; i++)
            if (elig[i] && m_ipr[i] > bp) begin best = i; bp = m_ipr[i]; end
        iprw = '0;
        for (int i = 0; i < N; i++) iprw[2*i +: 2] = 2'(m_ipr[i]);
        case (cfg_addr)
            2'd0:    rd = 16'(m_ier);
            2'd1:    rd = iprw[15:0];
            2'd2:    rd = {8'h00, iprw[23:16]};
            default: rd = 16'(m_pend);
        endcase
        clr = '0;
        if (cfg_we && cfg_addr == 2'd3) clr = cfg_wdata[N-1:0];
        if (m_mode == 1 && irq_ack) clr = clr | (12'b1 << m_vec);
        m_flag = '0;
        case (m_mode)
            0: if (best >= 0) begin m_mode = 1; m_req = 1'b1; m_vec = best; m_prio = bp; end
            1: if (irq_ack) begin m_mode = 2; m_req = 1'b0; m_flag = 12'b1 << m_vec; end
            default: if (irq_eoi) m_mode = 0;
        endcase
        m_pend  = (m_pend & ~clr) | rise;
        m_src_d = irq_src;
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: m_ier = cfg_wdata[N-1:0];
                2'd1: for (int i = 0; i < 8; i++) m_ipr[i] = int'(cfg_wdata[2*i +: 2]);
                2'd2: for (int i = 8; i < N; i++) m_ipr[i] = int'(cfg_wdata[2*(i-8) +: 2]);
                default: ;
            endcase
        end
        m_rdata = rd;
    endtask

    // Inputs are always changed 1 time unit after a rising edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("req", irq_req, m_req);
        if (m_req) begin
            check("vec", irq_vec, m_vec);
            check("prio", irq_prio, m_prio);
        end
        check("flag_clr", flag_clr, m_flag);
        check("rdata", cfg_rdata, m_rdata);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a);
        cfg_addr = a;
        cycle();
    endtask

    task automatic pulse(input int s);
        irq_src[s] = 1'b1;
        cycle();
        irq_src[s] = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int budget);
        int k = 0;
        while (!irq_req && k < budget) begin cycle(); k++; end
        check({tag, "_req"}, irq_req, 1);
    endtask

    task automatic serve();
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        irq_eoi = 1'b1; cycle(); irq_eoi = 1'b0;
    endtask

    int nreq, nflag;
    logic prev;

    initial begin
        model_reset();
        #1;
        check("rst_req", irq_req, 0);
        check("rst_vec", irq_vec, 0);
        check("rst_flag", flag_clr, 0);
        check("rst_rdata", cfg_rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single source latency and flag pulse
        cfg_write(ADDR_IER, 16'h0FFF);
        pulse(SRC_OVI1);
        check("t1_idle_early", irq_req, 0);
        cycle();
        check("t1_req", irq_req, 1);
        check("t1_vec", irq_vec, 5);
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        check("t1_flag", flag_clr, 12'h020);
        cycle();
        check("t1_flag_off", flag_clr, 0);
        irq_eoi = 1'b1; cycle(); irq_eoi = 1'b0;

        // Priority ordering with a tie
        cfg_write(ADDR_IPR_LO, 16'h8081);
        irq_src = 12'h089; cycle(); irq_src = '0;
        wait_req("t2a", 10); check("t2_vec_a", irq_vec, 3); serve();
        wait_req("t2b", 10); check("t2_vec_b", irq_vec, 7); serve();
        wait_req("t2c", 10); check("t2_vec_c", irq_vec, 0); serve();

        // Held level produces exactly one request
        nreq = 0; nflag = 0; prev = irq_req;
        irq_src[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            irq_ack = irq_req; irq_eoi = 1'b1;
            cycle();
            if (irq_req && !prev) nreq++;
            prev = irq_req;
            if (flag_clr[2]) nflag++;
        end
        irq_src[2] = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
        repeat (3) cycle();
        check("t3_nreq", nreq, 1);
        check("t3_nflag", nflag, 1);

        // Masked source still latches pending
        cfg_write(ADDR_IER, 16'h0FEF);
        pulse(SRC_CMIB1);
        repeat (3) cycle();
        check("t4_masked", irq_req, 0);
        cfg_read(ADDR_PEND);
        check("t4_pend", cfg_rdata, 16'h0010);
        cfg_write(ADDR_IER, 16'h0FFF);
        wait_req("t4", 10); check("t4_vec", irq_vec, 4); serve();

        // Frozen request and set-beats-clear on ack
        pulse(SRC_CMIA2);
        wait_req("t5", 10); check("t5_vec", irq_vec, 6);
        cfg_write(ADDR_PEND, 16'h0040);
        cfg_write(ADDR_IER, 16'h0000);
        repeat (2) cycle();
        check("t5_hold_req", irq_req, 1);
        check("t5_hold_vec", irq_vec, 6);
        irq_src[6] = 1'b1; irq_ack = 1'b1; cycle(); irq_ack = 1'b0; irq_src[6] = 1'b0;
        cfg_read(ADDR_PEND);
        check("t5_pend6", cfg_rdata[6], 1);
        irq_eoi = 1'b1; cycle(); irq_eoi = 1'b0;
        cfg_write(ADDR_IER, 16'h0FFF);
        wait_req("t5b", 10); serve();

        // Ack and eoi together: eoi ignored, no nesting while in service
        pulse(SRC_CMIB0);
        wait_req("t6", 10);
        irq_ack = 1'b1; irq_eoi = 1'b1; cycle(); irq_ack = 1'b0; irq_eoi = 1'b0;
        pulse(SRC_CMIA3);
        repeat (4) cycle();
        check("t6_svc", irq_req, 0);
        irq_eoi = 1'b1; cycle(); irq_eoi = 1'b0;
        wait_req("t6b", 5); check("t6_vec", irq_vec, 9);

        // Reset asserted during service
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        pulse(SRC_OVI3);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t7_req", irq_req, 0);
        check("t7_vec", irq_vec, 0);
        check("t7_prio", irq_prio, 0);
        check("t7_flag", flag_clr, 0);
        check("t7_rdata", cfg_rdata, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cfg_read(ADDR_PEND);
        check("t7_pend", cfg_rdata, 0);

        // Random traffic
        cfg_write(ADDR_IPR_LO, 16'($urandom));
        cfg_write(ADDR_IPR_HI, 16'($urandom));
        cfg_write(ADDR_IER, 16'h0FFF);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ (12'b1 << $urandom_range(0, N-1));
            irq_ack   = ($urandom_range(0, 2) == 0);
            irq_eoi   = ($urandom_range(0, 3) == 0);
            cfg_we    = ($urandom_range(0, 15) == 0);
            cfg_addr  = 2'($urandom);
            cfg_wdata = 16'($urandom);
            if (cfg_we && cfg_addr == ADDR_IER && $urandom_range(0, 1) == 0) cfg_wdata = 16'h0FFF;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
